// File: rtl/pc_fetch_control.sv
// pc_fetch_control
//   Program counter and circular return-address stack feeding the
//   instruction cache. Applies stage-4 redirects (taken NZT, XEC, CALL),
//   decode-stage redirects (JMP, RET), hazard stalls and cache misses.
//
// Ports:
//   clk             rising-edge clock
//   n_RST           synchronous reset, active-low
//   hazard          stall request; ignored when a redirect is present
//   pipeline_flush  stage-4 redirect valid
//   flush_target    stage-4 redirect address
//   push_valid      push push_addr onto the return stack (with pipeline_flush)
//   push_addr       return address to push
//   jmp_valid       decode-stage JMP
//   jmp_target      JMP destination
//   ret_valid       decode-stage RET (pops the return stack)
//   i_cache_ready   cache has data for fetch_addr this cycle
//   fetch_addr      current PC presented to the instruction cache
//   fetch_req       fetch request valid
//   decode_pc       address of the instruction in decode
//   stack_level     number of valid return-stack entries
//   stack_overflow  sticky: push while full
//   stack_underflow sticky: pop while empty
module pc_fetch_control #(
    parameter int unsigned       ADDR_W       = 16,
    parameter int unsigned       STACK_DEPTH  = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                         clk,
    input  logic                         n_RST,
    input  logic                         hazard,
    input  logic                         pipeline_flush,
    input  logic [ADDR_W-1:0]            flush_target,
    input  logic                         push_valid,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic                         jmp_valid,
    input  logic [ADDR_W-1:0]            jmp_target,
    input  logic                         ret_valid,
    input  logic                         i_cache_ready,
    output logic [ADDR_W-1:0]            fetch_addr,
    output logic                         fetch_req,
    output logic [ADDR_W-1:0]            decode_pc,
    output logic [$clog2(STACK_DEPTH):0] stack_level,
    output logic                         stack_overflow,
    output logic                         stack_underflow
);

    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(STACK_DEPTH);

    localparam logic [0:0] S_BOOT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]        state;
    logic              run;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  top_idx;
    logic [ADDR_W-1:0] top_addr;
    logic [LVL_W-1:0]  level;
    logic              stack_empty;
    logic              stack_full;
    logic              do_push;
    logic              do_pop;
    logic [ADDR_W-1:0] next_pc;
    logic              load_dpc;

    assign run         = (state == S_RUN);
    assign fetch_req   = run;
    assign stack_level = level;
    assign stack_empty = (level == '0);
    assign stack_full  = (level == FULL_LVL);

    // A RET under a flush is a younger, squashed instruction; a RET with a
    // JMP loses to the JMP. Neither pops.
    assign do_push = run & pipeline_flush & push_valid;
    assign do_pop  = run & ret_valid & ~pipeline_flush & ~jmp_valid;

    // Pop address is read combinationally so RET redirects with no bubble.
    assign top_idx  = ptr - PTR_W'(1);
    assign top_addr = stack_mem[top_idx];

    always_comb begin
        next_pc  = fetch_addr;
        load_dpc = 1'b0;
        if (run) begin
            if (pipeline_flush) begin
                next_pc  = flush_target;
                load_dpc = 1'b1;
            end else if (jmp_valid) begin
                next_pc  = jmp_target;
                load_dpc = 1'b1;
            end else if (ret_valid) begin
                next_pc  = stack_empty ? RESET_VECTOR : top_addr;
                load_dpc = 1'b1;
            end else if (!hazard && i_cache_ready) begin
                next_pc  = fetch_addr + ADDR_W'(1);
                load_dpc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_RST) begin
            state           <= S_BOOT;
            fetch_addr      <= RESET_VECTOR;
            decode_pc       <= RESET_VECTOR;
            ptr             <= '0;
            level           <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            state      <= S_RUN;
            fetch_addr <= next_pc;
            if (load_dpc) begin
                decode_pc <= fetch_addr;
            end
            // When full the pointer already addresses the oldest entry, so a
            // push overwrites it and the level saturates.
            if (do_push) begin
                ptr <= ptr + PTR_W'(1);
                if (stack_full) begin
                    stack_overflow <= 1'b1;
                end else begin
                    level <= level + LVL_W'(1);
                end
            end else if (do_pop) begin
                if (stack_empty) begin
                    stack_underflow <= 1'b1;
                end else begin
                    ptr   <= top_idx;
                    level <= level - LVL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_RST && do_push) begin
            stack_mem[ptr] <= push_addr;
        end
    end

endmodule

// File: tb/tb_pc_fetch_control.sv
module tb_pc_fetch_control;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 8;
    localparam logic [15:0] RV     = 16'h0000;

    logic        clk = 1'b0;
    logic        n_RST, hazard, pipeline_flush, push_valid, jmp_valid, ret_valid, i_cache_ready;
    logic [15:0] flush_target, push_addr, jmp_target;
    logic [15:0] fetch_addr, decode_pc;
    logic        fetch_req, stack_overflow, stack_underflow;
    logic [3:0]  stack_level;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_run;
    logic [15:0] m_pc, m_dpc;
    logic [15:0] m_stk[$];
    bit          m_ovf, m_unf;

    always #5 clk = ~clk;

    pc_fetch_control #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (DEPTH),
        .RESET_VECTOR(RV)
    ) dut (
        .clk            (clk),
        .n_RST          (n_RST),
        .hazard         (hazard),
        .pipeline_flush (pipeline_flush),
        .flush_target   (flush_target),
        .push_valid     (push_valid),
        .push_addr      (push_addr),
        .jmp_valid      (jmp_valid),
        .jmp_target     (jmp_target),
        .ret_valid      (ret_valid),
        .i_cache_ready  (i_cache_ready),
        .fetch_addr     (fetch_addr),
        .fetch_req      (fetch_req),
        .decode_pc      (decode_pc),
        .stack_level    (stack_level),
        .stack_overflow (stack_overflow),
        .stack_underflow(stack_underflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: LIFO queue capped at DEPTH, oldest dropped on overflow.
    task automatic model_step();
        logic [15:0] old;
        if (!n_RST) begin
            m_run = 0; m_pc = RV; m_dpc = RV; m_ovf = 0; m_unf = 0;
            m_stk.delete();
        end else if (!m_run) begin
            m_run = 1;
        end else begin
            old = m_pc;
            if (pipeline_flush) begin
                if (push_valid) begin
                    if (m_stk.size() == DEPTH) begin
                        void'(m_stk.pop_front());
                        m_ovf = 1;
                    end
                    m_stk.push_back(push_addr);
                end
                m_pc = flush_target; m_dpc = old;
            end else if (jmp_valid) begin
                m_pc = jmp_target; m_dpc = old;
            end else if (ret_valid) begin
                if (m_stk.size() == 0) begin
                    m_pc = RV; m_unf = 1;
                end else begin
                    m_pc = m_stk.pop_back();
                end
                m_dpc = old;
            end else if (!hazard && i_cache_ready) begin
                m_pc = old + 16'd1; m_dpc = old;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("fetch_addr", 32'(fetch_addr), 32'(m_pc));
        check_eq("fetch_req", 32'(fetch_req), 32'(m_run));
        check_eq("decode_pc", 32'(decode_pc), 32'(m_dpc));
        check_eq("stack_level", 32'(stack_level), 32'(m_stk.size()));
        check_eq("stack_overflow", 32'(stack_overflow), 32'(m_ovf));
        check_eq("stack_underflow", 32'(stack_underflow), 32'(m_unf));
    endtask

    // One clock: drive, edge, model, then sample 1 time unit after the edge.
    task automatic cyc(input logic rst, input logic haz, input logic icr,
                       input logic fl, input logic [15:0] ft,
                       input logic pv, input logic [15:0] pa,
                       input logic jv, input logic [15:0] jt,
                       input logic rv);
        n_RST = rst; hazard = haz; i_cache_ready = icr;
        pipeline_flush = fl; flush_target = ft;
        push_valid = pv; push_addr = pa;
        jmp_valid = jv; jmp_target = jt; ret_valid = rv;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0);
    endtask

    task automatic do_reset();
        cyc(0, 1, 0, 1, 16'hdead, 1, 16'hbeef, 1, 16'h5555, 1);
        cyc(0, 0, 1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0);
        check_eq("reset_fetch_addr", 32'(fetch_addr), 32'(RV));
        check_eq("reset_fetch_req", 32'(fetch_req), 32'd0);
    endtask

    initial begin
        n_RST = 0; hazard = 0; pipeline_flush = 0; push_valid = 0;
        jmp_valid = 0; ret_valid = 0; i_cache_ready = 1;
        flush_target = '0; push_addr = '0; jmp_target = '0;

        // Boot and sequential fetch
        do_reset();
        idle(1);
        check_eq("boot_done_req", 32'(fetch_req), 32'd1);
        check_eq("boot_pc", 32'(fetch_addr), 32'h0000);
        idle(5);
        check_eq("pc_at_5", 32'(fetch_addr), 32'h0005);

        // Stall via hazard, then via cache miss
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0);
        check_eq("hazard_hold", 32'(fetch_addr), 32'h0005);
        idle(1);
        check_eq("after_hazard", 32'(fetch_addr), 32'h0006);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0);
        check_eq("miss_hold", 32'(fetch_addr), 32'h0006);

        // JMP overrides hazard
        cyc(1, 1, 1, 0, 16'h0, 0, 16'h0, 1, 16'h1234, 0);
        check_eq("jmp_under_hazard", 32'(fetch_addr), 32'h1234);

        // CALL then RET
        cyc(1, 1, 0, 1, 16'h0100, 1, 16'h0043, 0, 16'h0, 0);
        check_eq("call_target", 32'(fetch_addr), 32'h0100);
        check_eq("call_level", 32'(stack_level), 32'd1);
        idle(3);
        cyc(1, 1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 1);
        check_eq("ret_addr", 32'(fetch_addr), 32'h0043);
        check_eq("ret_level", 32'(stack_level), 32'd0);

        // Overflow with 9 pushes, then 8 pops and an underflowing pop
        for (int i = 1; i <= 9; i++)
            cyc(1, 0, 1, 1, 16'(16'h0300 + i), 1, 16'(i), 0, 16'h0, 0);
        check_eq("ovf_flag", 32'(stack_overflow), 32'd1);
        check_eq("ovf_level", 32'(stack_level), 32'd8);
        for (int i = 9; i >= 2; i--) begin
            cyc(1, 0, 1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 1);
            check_eq("pop_order", 32'(fetch_addr), 32'(i));
        end
        cyc(1, 0, 1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 1);
        check_eq("underflow_pc", 32'(fetch_addr), 32'(RV));
        check_eq("underflow_flag", 32'(stack_underflow), 32'd1);
        idle(2);
        check_eq("sticky_ovf", 32'(stack_overflow), 32'd1);

        // Flush squashes a concurrent RET
        do_reset();
        idle(1);
        cyc(1, 0, 1, 1, 16'h0010, 1, 16'h0aaa, 0, 16'h0, 0);
        cyc(1, 0, 1, 1, 16'h0020, 1, 16'h0bbb, 0, 16'h0, 0);
        cyc(1, 0, 1, 1, 16'h0200, 0, 16'h0, 0, 16'h0, 1);
        check_eq("flush_vs_ret_pc", 32'(fetch_addr), 32'h0200);
        check_eq("flush_vs_ret_lvl", 32'(stack_level), 32'd2);
        // JMP beats RET, no pop
        cyc(1, 0, 1, 0, 16'h0, 0, 16'h0, 1, 16'h0777, 1);
        check_eq("jmp_vs_ret_lvl", 32'(stack_level), 32'd2);

        // Wrap of PC at the top of the address space
        cyc(1, 0, 1, 0, 16'h0, 0, 16'h0, 1, 16'hfffe, 0);
        idle(2);
        check_eq("pc_wrap", 32'(fetch_addr), 32'h0000);

        // Randomised traffic, including resets mid-stall or mid-miss
        for (int i = 0; i < 3000; i++) begin
            logic r_rst, r_fl, r_jv, r_rv;
            r_rst = ($urandom_range(0, 199) != 0);
            r_fl  = ($urandom_range(0, 99) < 12);
            r_jv  = ($urandom_range(0, 99) < 8);
            r_rv  = ($urandom_range(0, 99) < 15);
            cyc(r_rst, ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 80),
                r_fl, 16'($urandom), ($urandom_range(0, 1) == 1), 16'($urandom),
                r_jv, 16'($urandom), r_rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_control.md
Name: pc_fetch_control

Overview:
Program-counter and return-stack block directly upstream of the decoder and hazard unit. It generates the instruction fetch address each cycle and consumes the hazard unit's stall and flush outputs. It applies decode-stage redirects (JMP, RET) and stage-4 redirects (taken NZT, XEC, CALL), and keeps a small circular return-address stack for CALL/RET.

Parameters:
ADDR_W, 16, width of program counter and all addresses
STACK_DEPTH, 8, return-stack entries (power of two, 2..16)
RESET_VECTOR, 16'h0000, PC value loaded on reset and on stack underflow

Ports:
clk  in  1  rising-edge clock
n_RST  in  1  synchronous reset, active-low
hazard  in  1  stall request from hazard unit; holds PC unless a redirect is present
pipeline_flush  in  1  stage-4 redirect valid (taken NZT, XEC or CALL)
flush_target  in  ADDR_W  stage-4 redirect address
push_valid  in  1  push push_addr onto return stack (CALL4; qualified by pipeline_flush)
push_addr  in  ADDR_W  return address to push
jmp_valid  in  1  decode-stage JMP, already gated by ~branch_hazard
jmp_target  in  ADDR_W  JMP destination
ret_valid  in  1  decode-stage RET, already gated by ~branch_hazard
i_cache_ready  in  1  instruction cache has data for fetch_addr this cycle
fetch_addr  out  ADDR_W  current PC presented to instruction cache
fetch_req  out  1  fetch request valid
decode_pc  out  ADDR_W  address of the instruction currently in decode
stack_level  out  log2(STACK_DEPTH)+1  valid entries on stack
stack_overflow  out  1  sticky: push while full
stack_underflow  out  1  sticky: pop while empty

Behaviour:
- Reset (n_RST=0 at clk edge): fetch_addr=RESET_VECTOR, decode_pc=RESET_VECTOR, fetch_req=0, stack_level=0, both sticky flags=0, state=BOOT. Stack RAM contents are don't-care.
- States:
  - BOOT: one cycle, fetch_req=0, then unconditionally go to RUN.
  - RUN: fetch_req=1.
  - Redirect inputs are ignored in BOOT.
- Next-PC priority in RUN, evaluated each edge:
  1. pipeline_flush -> flush_target.
  2. jmp_valid -> jmp_target.
  3. ret_valid -> top of stack (pop).
  4. hazard or ~i_cache_ready -> hold.
  5. otherwise fetch_addr+1, wrapping modulo 2^ADDR_W.
- Redirects (priorities 1-3) override hazard and i_cache_ready. The hazard unit asserts hazard during decoder flushes, so this is mandatory.
- decode_pc: loads the old fetch_addr when the PC advances by increment. Holds on stall. Loads the old fetch_addr on any redirect as well; the decoder is reset by decoder_RST in that case, so the value is don't-care.
- Latency: redirect applied on edge N, new fetch_addr visible after edge N, so a zero-bubble fetch the following cycle.
- Stack:
  - Push: when pipeline_flush & push_valid. Write push_addr at pointer, increment pointer.
  - Pop: when ret_valid and no pipeline_flush. Read entry pointer-1, decrement pointer.
  - ret_valid during pipeline_flush is a younger, flushed instruction: no pop, no PC effect.
  - jmp_valid and ret_valid together never occur; if they do, jmp wins and no pop.
  - Full push (stack_level==STACK_DEPTH): overwrite the oldest entry circularly. stack_level stays STACK_DEPTH. Set stack_overflow.
  - Empty pop (stack_level==0): next PC=RESET_VECTOR, stack_level stays 0, set stack_underflow.
  - Push and pop in the same cycle cannot happen: pop is suppressed by pipeline_flush.
  - Stack read is combinational from registered storage. The popped address is valid in the same cycle ret_valid is high.
- Sticky flags clear only on reset.
- Reset mid-miss or mid-stall: reset wins over all inputs and returns to BOOT.

Test Plan:
- Reset release, i_cache_ready=1, no hazards -> BOOT 1 cycle with fetch_req=0, then fetch_addr 0000,0001,0002; decode_pc lags by one.
- PC at 0005, hazard=1 for 3 cycles -> fetch_addr holds 0005 for 3 cycles, then 0006; same hold with i_cache_ready=0.
- jmp_valid, jmp_target=0x1234, with hazard=1 -> fetch_addr=0x1234 next cycle.
- pipeline_flush + push_valid, flush_target=0x0100, push_addr=0x0043, then ret_valid later -> fetch_addr 0x0100, later 0x0043; stack_level 1 then 0.
- 9 pushes with STACK_DEPTH=8 (addrs 1..9), then 8 pops -> stack_overflow=1; pops return 9,8,...,2; a 9th pop -> fetch_addr=RESET_VECTOR, stack_underflow=1.
- pipeline_flush (target 0x0200) and ret_valid in the same cycle with stack_level=2 -> fetch_addr=0x0200, stack_level stays 2.
